// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and sizing helper for the debounce scan controller
package debounce_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } scan_state_t;

  // Stability counter must hold values up to STABLE_TICKS for the terminal compare.
  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

endpackage

// File: rtl/debounce_scan_ctrl_tick_gen.sv
// rtl/debounce_scan_ctrl_tick_gen.sv - free-running debounce tick prescaler
module tick_gen #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  // Gated by en so a count frozen at DIV-1 cannot stretch the pulse.
  assign tick = en & w_wrap;

endmodule

// File: rtl/debounce_scan_ctrl.sv
// rtl/debounce_scan_ctrl.sv - multi-channel switch debouncer with one time-shared engine
module debounce_scan_ctrl
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 1_000_000,
  parameter int STABLE_TICKS = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] db,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            tick
);

  localparam int CW = cnt_width(STABLE_TICKS);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  // A sweep takes N_CH cycles after the tick; the next tick must not land inside it.
  if (TICK_DIV < N_CH + 2) begin : g_div_check
    $error("debounce_scan_ctrl: TICK_DIV must be >= N_CH+2");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_nch_check
    $error("debounce_scan_ctrl: N_CH must be in 1..16");
  end
  if (STABLE_TICKS < 1) begin : g_stable_check
    $error("debounce_scan_ctrl: STABLE_TICKS must be >= 1");
  end

  logic [N_CH-1:0]         r_sync1;
  logic [N_CH-1:0]         r_sync2;
  logic [N_CH-1:0]         r_db;
  logic [N_CH-1:0]         r_rise;
  logic [N_CH-1:0]         r_fall;
  logic [N_CH-1:0][CW-1:0] r_cnt;
  scan_state_t             r_state;
  logic [IW-1:0]           r_idx;

  scan_state_t             w_state_nxt;
  logic [IW-1:0]           w_idx_nxt;
  logic                    w_svc;
  logic                    w_tick;
  logic                    w_sw_sel;
  logic                    w_db_sel;
  logic [CW-1:0]           w_cnt_sel;
  logic [CW-1:0]           w_cnt_inc;
  logic                    w_done;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_svc       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_state_nxt = S_SCAN;
          w_idx_nxt   = '0;
        end
      end
      S_SCAN: begin
        w_svc = 1'b1;
        if (r_idx == IW'(N_CH - 1)) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign w_sw_sel  = r_sync2[r_idx];
  assign w_db_sel  = r_db[r_idx];
  assign w_cnt_sel = r_cnt[r_idx];
  assign w_cnt_inc = w_cnt_sel + 1'b1;
  assign w_done    = (w_cnt_inc == CW'(STABLE_TICKS));

  // Only the channel under the scan pointer is touched; event pulses self-clear next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db   <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_cnt  <= '0;
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      if (w_svc) begin
        if (w_sw_sel == w_db_sel) begin
          r_cnt[r_idx] <= '0;
        end else if (!w_done) begin
          r_cnt[r_idx] <= w_cnt_inc;
        end else begin
          r_cnt[r_idx]  <= '0;
          r_db[r_idx]   <= w_sw_sel;
          r_rise[r_idx] <= w_sw_sel;
          r_fall[r_idx] <= ~w_sw_sel;
        end
      end
    end
  end

  assign db   = r_db;
  assign rise = r_rise;
  assign fall = r_fall;
  assign tick = w_tick;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// tb/tb_debounce_scan_ctrl.sv - directed self-checking bench for debounce_scan_ctrl
module tb_debounce_scan_ctrl;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] sw;
  logic [3:0] db;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       tick;

  int n_tests;
  int n_fail;

  debounce_scan_ctrl #(
    .N_CH         (4),
    .TICK_DIV     (8),
    .STABLE_TICKS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .sw    (sw),
    .db    (db),
    .rise  (rise),
    .fall  (fall),
    .tick  (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scenarios: 0 press+release, 1 bounce, 2 simultaneous, 3 en low
  function automatic logic [3:0] stim_sw(input int sc, input int c);
    case (sc)
      0:       return (c < 40) ? 4'b0010 : 4'b0000;
      1:       return ((c <= 20) && (((c / 3) % 2) == 1)) ? 4'b0000 : 4'b0100;
      2:       return 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic stim_en(input int sc, input int c);
    return !((sc == 3) && (c >= 10) && (c < 30));
  endfunction

  function automatic logic exp_tick(input int sc, input int c);
    if (sc == 3) return (c == 7) || (c == 35) || (c == 43);
    return (c % 8) == 7;
  endfunction

  function automatic logic [3:0] exp_db(input int sc, input int c);
    logic [3:0] v;
    v = 4'b0000;
    case (sc)
      0: if (c >= 26 && c < 66) v = 4'b0010;
      1: if (c >= 43) v = 4'b0100;
      2: for (int k = 0; k < 4; k++) v[k] = (c >= 25 + k);
      default: if (c >= 45) v = 4'b0001;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] exp_rise(input int sc, input int c);
    logic [3:0] v;
    v = 4'b0000;
    case (sc)
      0: if (c == 26) v = 4'b0010;
      1: if (c == 43) v = 4'b0100;
      2: for (int k = 0; k < 4; k++) v[k] = (c == 25 + k);
      default: if (c == 45) v = 4'b0001;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] exp_fall(input int sc, input int c);
    return ((sc == 0) && (c == 66)) ? 4'b0010 : 4'b0000;
  endfunction

  task automatic check_zero(input string pfx);
    check({pfx, "_db"},   32'(db),   32'h0);
    check({pfx, "_rise"}, 32'(rise), 32'h0);
    check({pfx, "_fall"}, 32'(fall), 32'h0);
    check({pfx, "_tick"}, 32'(tick), 32'h0);
  endtask

  // Inputs change and outputs are sampled on the falling edge; cycle 0 starts at reset release.
  task automatic run(input int sc, input int ncyc);
    reset = 1'b1;
    sw    = 4'b0000;
    en    = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_zero($sformatf("s%0d_rst", sc));
    for (int c = 0; c < ncyc; c++) begin
      if (c == 0) reset = 1'b0;
      sw = stim_sw(sc, c);
      en = stim_en(sc, c);
      #1;
      check($sformatf("s%0d_c%0d_db", sc, c),   32'(db),   32'(exp_db(sc, c)));
      check($sformatf("s%0d_c%0d_rise", sc, c), 32'(rise), 32'(exp_rise(sc, c)));
      check($sformatf("s%0d_c%0d_fall", sc, c), 32'(fall), 32'(exp_fall(sc, c)));
      check($sformatf("s%0d_c%0d_tick", sc, c), 32'(tick), 32'(exp_tick(sc, c)));
      @(negedge clk);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    en      = 1'b1;
    sw      = 4'b0000;
    @(negedge clk);

    run(0, 72);
    run(1, 50);
    run(2, 32);
    run(3, 50);

    // Reset lands in cycle 25, the cycle db[0]/rise[0] would first show.
    run(2, 25);
    reset = 1'b1;
    #1;
    check_zero("midscan_rst");
    run(2, 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
